// File: rtl/core_pkg.sv
// Shared fetch/decode types: PC and instruction widths plus the buffered entry.
package core_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 12;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : core_pkg

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue. This is an in-order circular buffer of
// DEPTH {pc, instr} entries. A taken branch (flush) drops every buffered word.
// All outputs come from registered state only.
module instr_queue
    import core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enq_valid,
    input  logic [PC_W-1:0]    enq_pc,
    input  logic [INSTR_W-1:0] enq_instr,
    output logic               enq_ready,
    input  logic               flush,
    output logic               deq_valid,
    output logic [PC_W-1:0]    deq_pc,
    output logic [INSTR_W-1:0] deq_instr,
    input  logic               deq_ready,
    output logic [CNT_W-1:0]   count,
    output logic               overflow
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    fetch_entry_t     mem_q [DEPTH];

    logic do_enq;
    logic do_deq;

    // count alone decides full/empty. The pointers never do, so head==tail stays unambiguous.
    assign enq_ready = (count_q != CNT_W'(DEPTH));
    assign deq_valid = (count_q != '0);
    assign do_enq    = enq_valid && enq_ready && !flush;
    assign do_deq    = deq_valid && deq_ready && !flush;

    assign deq_pc    = mem_q[head_q].pc;
    assign deq_instr = mem_q[head_q].instr;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        // A flushed cycle discards the enqueue attempt, so it cannot raise overflow.
        overflow_d = overflow_q | (enq_valid && !enq_ready && !flush);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer increments wrap by truncation.
            if (do_enq) tail_d = tail_q + PTR_W'(1);
            if (do_deq) head_d = head_q + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state update. Reset takes priority over flush and over the handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage. It is never cleared, and stale words sit behind count until overwritten.
    always_ff @(posedge clk) begin
        if (rst_n && do_enq) begin
            mem_q[tail_q] <= '{pc: enq_pc, instr: enq_instr};
        end
    end

endmodule : instr_queue

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios followed by random traffic.
// Results are compared against a queue-based reference model.
module tb_instr_queue;
    import core_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enq_valid = 1'b0;
    logic [PC_W-1:0]    enq_pc = '0;
    logic [INSTR_W-1:0] enq_instr = '0;
    logic               enq_ready;
    logic               flush = 1'b0;
    logic               deq_valid;
    logic [PC_W-1:0]    deq_pc;
    logic [INSTR_W-1:0] deq_instr;
    logic               deq_ready = 1'b0;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: the list of buffered words, oldest first, plus the sticky flag.
    fetch_entry_t mq[$];
    bit           movf = 1'b0;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr), .enq_ready(enq_ready),
        .flush(flush),
        .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr), .deq_ready(deq_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Compare every DUT output against the model state.
    task automatic check_all(input string tag);
        chk({tag, ".count"},     32'(count),     32'(mq.size()));
        chk({tag, ".enq_ready"}, 32'(enq_ready), 32'(mq.size() < DEPTH));
        chk({tag, ".deq_valid"}, 32'(deq_valid), 32'(mq.size() > 0));
        chk({tag, ".overflow"},  32'(overflow),  32'(movf));
        if (mq.size() > 0) begin
            chk({tag, ".deq_pc"},    32'(deq_pc),    32'(mq[0].pc));
            chk({tag, ".deq_instr"}, 32'(deq_instr), 32'(mq[0].instr));
        end
    endtask

    // Drive one cycle of inputs and advance the model by the queue's rules.
    // Then check the outputs 1 time unit after the edge.
    task automatic cyc(input string tag, input bit rn, input bit fl, input bit ev,
                       input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins, input bit dr);
        bit full;
        rst_n = rn; flush = fl; enq_valid = ev; enq_pc = pc; enq_instr = ins; deq_ready = dr;
        full = (mq.size() == DEPTH);
        if (!rn) begin
            mq.delete();
            movf = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (ev && full) movf = 1'b1;
            if (dr && mq.size() > 0) void'(mq.pop_front());
            if (ev && !full) mq.push_back('{pc: pc, instr: ins});
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset and then idle.
        cyc("rst0", 0, 0, 0, '0, '0, 0);
        cyc("rst1", 0, 0, 0, '0, '0, 0);
        cyc("idle", 1, 0, 0, '0, '0, 0);
        chk("idle.count_zero", 32'(count), 32'd0);

        // Fill the queue and then drain it in order.
        for (int i = 0; i < 4; i++)
            cyc("fill", 1, 0, 1, PC_W'(i), INSTR_W'(12'hA00 + i), 0);
        chk("fill.count4", 32'(count), 32'd4);
        chk("fill.full", 32'(enq_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drain.pc", 32'(deq_pc), 32'(i));
            chk("drain.instr", 32'(deq_instr), 32'(12'hA00 + i));
            cyc("drain", 1, 0, 0, '0, '0, 1);
        end
        chk("drain.empty", 32'(deq_valid), 32'd0);

        // Streaming across the pointer and PC wrap. Count settles at 1.
        for (int i = 0; i < 10; i++)
            cyc("stream", 1, 0, 1, PC_W'(10'h3FC + i), INSTR_W'(12'hB00 + i), 1);
        chk("stream.count1", 32'(count), 32'd1);
        chk("stream.last_pc", 32'(deq_pc), 32'h005);
        cyc("stream_end", 1, 0, 0, '0, '0, 1);

        // With the queue full, a same-cycle dequeue does not admit the new word.
        for (int i = 0; i < 4; i++)
            cyc("fill2", 1, 0, 1, PC_W'(10'h100 + i), INSTR_W'(12'hC00 + i), 0);
        cyc("full_deq_enq", 1, 0, 1, 10'h1FF, 12'hFFF, 1);
        chk("full.count3", 32'(count), 32'd3);
        chk("full.overflow", 32'(overflow), 32'd1);
        chk("full.ready_back", 32'(enq_ready), 32'd1);

        // Flush in the same cycle as an enqueue and a dequeue.
        cyc("flush", 1, 1, 1, 10'h2AA, 12'h555, 1);
        chk("flush.count0", 32'(count), 32'd0);
        chk("flush.ovf_kept", 32'(overflow), 32'd1);

        // Reset in mid-stream.
        cyc("pre_rst", 1, 0, 1, 10'h010, 12'h111, 0);
        cyc("pre_rst", 1, 0, 1, 10'h011, 12'h112, 0);
        chk("pre_rst.count2", 32'(count), 32'd2);
        cyc("mid_rst", 0, 0, 1, 10'h012, 12'h113, 1);
        chk("mid_rst.count0", 32'(count), 32'd0);
        chk("mid_rst.ovf0", 32'(overflow), 32'd0);
        chk("mid_rst.ready", 32'(enq_ready), 32'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                $urandom_range(99) >= 2,
                $urandom_range(99) < 5,
                $urandom_range(99) < 70,
                PC_W'($urandom), INSTR_W'($urandom),
                $urandom_range(99) < 55);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_queue
